fan_off_timer: RTL and testbench
================================

FAN_OFF_TIMER -- requirements
Module: fan_off_timer

Interface
REQ-001 The block SHALL have parameter CYC_PER_SEC, default 125_000_000, giving clk cycles per timer second.
REQ-002 The block SHALL have parameter PRESET_1, default 3600, giving the first preset in seconds.
REQ-003 The block SHALL have parameter PRESET_2, default 10800, giving the second preset in seconds.
REQ-004 The block SHALL have parameter PRESET_3, default 18000, giving the third preset in seconds.
REQ-005 The block SHALL have parameter WARN_SEC, default 60, giving the warning threshold in seconds.
REQ-006 The block SHALL have port clk, input, 1 bit: the single system clock.
REQ-007 The block SHALL have port reset_p, input, 1 bit: synchronous, active-high reset.
REQ-008 The block SHALL have port btn_timer, input, 1 bit: one-cycle pulse from the debounced button that cycles the preset.
REQ-009 The block SHALL have port fan_en, input, 1 bit: fan subsystem enable.
REQ-010 The block SHALL have port run_e, input, 1 bit: the fan speed controller's running flag.
REQ-011 The block SHALL have port set_idle, output, 1 bit: one-cycle pulse that forces the fan controller to IDLE.
REQ-012 The block SHALL have port timer_state, output, 4 bits: one-hot state {T_3, T_2, T_1, T_OFF}.
REQ-013 The block SHALL have port remain_sec, output, 16 bits: seconds remaining, 0 in T_OFF.
REQ-014 The block SHALL have port warn, output, 1 bit: timer is near expiry.

Function
REQ-015 The FSM SHALL have states T_OFF, T_1, T_2 and T_3; each btn_timer pulse SHALL advance T_OFF→T_1→T_2→T_3→T_OFF.
REQ-016 Entering T_n SHALL load remain_sec with PRESET_n and clear the second prescaler on the same edge.
REQ-017 Entering T_OFF SHALL clear remain_sec.
REQ-018 The prescaler SHALL count only while the state is not T_OFF and run_e=1; while run_e=0 the prescaler and remain_sec SHALL hold (pause).
REQ-019 A one-cycle sec_tick SHALL occur every CYC_PER_SEC counting cycles; on each sec_tick, remain_sec SHALL decrement by 1.
REQ-020 When a sec_tick occurs with remain_sec=1:
  - remain_sec SHALL become 0 and the state SHALL become T_OFF on that edge;
  - set_idle SHALL be high for exactly the following one cycle.
REQ-021 fan_en=0 SHALL force T_OFF and remain_sec=0 on the next edge, with no set_idle pulse.
REQ-022 Priority SHALL be: fan_en=0, then expiry, then btn_timer; a btn_timer pulse coincident with expiry SHALL be ignored.
REQ-023 btn_timer SHALL be ignored while fan_en=0.
REQ-024 remain_sec SHALL never wrap below 0.
REQ-025 Preset values larger than 65535 SHALL be rejected by an elaboration-time check.
REQ-026 All outputs SHALL be registered.

Reset
REQ-027 On reset_p (synchronous), the block SHALL set: state T_OFF (timer_state=4'b0001), remain_sec=0, set_idle=0, warn=0, prescaler=0.
REQ-028 Reset asserted mid-countdown SHALL discard the countdown and SHALL NOT produce a set_idle pulse.

Configuration
REQ-029 With macro FAN_TIMER_WARN_EN defined, warn SHALL be high while the state is not T_OFF and 0 < remain_sec ≤ WARN_SEC.
REQ-030 Without FAN_TIMER_WARN_EN, warn SHALL be tied 0 and no comparator logic SHALL be generated.

Structure
REQ-031 A shared package fan_pkg SHALL hold the one-hot timer state constants and the default preset/WARN constants.
REQ-032 The prescaler SHALL be a sub-module sec_prescaler with ports (clk, reset_p, clr, en, tick) and parameter CYC_PER_SEC.

Verification
(Bench parameters for all scenarios: CYC_PER_SEC=10, PRESET_1/2/3=3/6/9, WARN_SEC=2.)
REQ-033 Bench scenario SHALL cover: fan_en=1, run_e=1, one btn_timer pulse → timer_state=0010, remain_sec=3, decrements every 10 cycles; set_idle pulses once 30 cycles later; final state 0001.
REQ-034 Bench scenario SHALL cover: four btn_timer pulses 5 cycles apart → states 0010, 0100, 1000, 0001 with remain_sec 3, 6, 9, 0; no set_idle pulse.
REQ-035 Bench scenario SHALL cover: T_1 started, run_e=0 for 50 cycles after 15 counting cycles → remain_sec holds at 2; expiry occurs 15 counting cycles after run_e returns to 1.
REQ-036 Bench scenario SHALL cover: btn_timer pulse on the expiry cycle → state T_OFF, set_idle pulses once, btn ignored.
REQ-037 Bench scenario SHALL cover: fan_en=0 mid-count in T_2 → next cycle state 0001, remain_sec=0, set_idle stays 0.
REQ-038 Bench scenario SHALL cover: reset_p for 1 cycle at remain_sec=1 → all outputs at reset values, no set_idle; warn is 1 at remain_sec=2 and 1 only when FAN_TIMER_WARN_EN is defined.

Source files
------------

// File: rtl/fan_pkg.sv
// Shared definitions for the fan off-timer: one-hot timer states,
// default presets and the warning threshold.
package fan_pkg;

   // One-hot timer states, bit order {T_3, T_2, T_1, T_OFF}
   typedef enum logic [3:0] {
      T_OFF = 4'b0001,
      T_1   = 4'b0010,
      T_2   = 4'b0100,
      T_3   = 4'b1000
   } timer_state_t;

   localparam int unsigned DEF_CYC_PER_SEC = 125_000_000;
   localparam int unsigned DEF_PRESET_1    = 3600;
   localparam int unsigned DEF_PRESET_2    = 10800;
   localparam int unsigned DEF_PRESET_3    = 18000;
   localparam int unsigned DEF_WARN_SEC    = 60;

   // Button cycling order T_OFF -> T_1 -> T_2 -> T_3 -> T_OFF
   function automatic timer_state_t next_preset(input timer_state_t s);
      timer_state_t n;
      unique case (s)
         T_OFF:   n = T_1;
         T_1:     n = T_2;
         T_2:     n = T_3;
         default: n = T_OFF;
      endcase
      return n;
   endfunction

endpackage

// File: rtl/sec_prescaler.sv
// Divides clk down to a one-cycle tick every CYC_PER_SEC enabled cycles.
module sec_prescaler #(
   parameter int unsigned CYC_PER_SEC = 125_000_000
) (
   input  logic clk,
   input  logic reset_p,
   input  logic clr,
   input  logic en,
   output logic tick
);

   localparam int unsigned   CW   = (CYC_PER_SEC > 1) ? $clog2(CYC_PER_SEC) : 1;
   localparam logic [CW-1:0] LAST = CW'(CYC_PER_SEC - 1);

   logic [CW-1:0] cnt;

   assign tick = en && (cnt == LAST);

   // Cycle counter: cleared on request, advances only while enabled
   always_ff @(posedge clk) begin
      if (reset_p) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (en) begin
         cnt <= tick ? '0 : cnt + 1'b1;
      end
   end

endmodule

// File: rtl/fan_off_timer.sv
// Fan off-timer: a button cycles through three countdown presets; on
// expiry the fan controller is forced to IDLE with a one-cycle set_idle.
// Optional macro FAN_TIMER_WARN_EN enables the near-expiry warn output.
module fan_off_timer
   import fan_pkg::*;
#(
   parameter int unsigned CYC_PER_SEC = DEF_CYC_PER_SEC,
   parameter int unsigned PRESET_1    = DEF_PRESET_1,
   parameter int unsigned PRESET_2    = DEF_PRESET_2,
   parameter int unsigned PRESET_3    = DEF_PRESET_3,
   parameter int unsigned WARN_SEC    = DEF_WARN_SEC
) (
   input  logic        clk,
   input  logic        reset_p,
   input  logic        btn_timer,
   input  logic        fan_en,
   input  logic        run_e,
   output logic        set_idle,
   output logic [3:0]  timer_state,
   output logic [15:0] remain_sec,
   output logic        warn
);

   if (PRESET_1 > 65535 || PRESET_2 > 65535 || PRESET_3 > 65535) begin : g_bad_preset
      $error("fan_off_timer: preset exceeds 16-bit remain_sec range");
   end
   if (WARN_SEC > 65535 || CYC_PER_SEC == 0) begin : g_bad_cfg
      $error("fan_off_timer: invalid WARN_SEC or CYC_PER_SEC");
   end

   localparam logic [15:0] P1 = 16'(PRESET_1);
   localparam logic [15:0] P2 = 16'(PRESET_2);
   localparam logic [15:0] P3 = 16'(PRESET_3);

   timer_state_t state, state_nx;
   logic [15:0]  remain_nx;
   logic         idle_nx;
   logic         pre_clr;
   logic         pre_en;
   logic         sec_tick;

   assign pre_en      = (state != T_OFF) && run_e;
   assign timer_state = state;

   sec_prescaler #(
      .CYC_PER_SEC (CYC_PER_SEC)
   ) u_prescaler (
      .clk     (clk),
      .reset_p (reset_p),
      .clr     (pre_clr),
      .en      (pre_en),
      .tick    (sec_tick)
   );

   // State, countdown and set_idle registers
   always_ff @(posedge clk) begin
      if (reset_p) begin
         state      <= T_OFF;
         remain_sec <= '0;
         set_idle   <= 1'b0;
      end else begin
         state      <= state_nx;
         remain_sec <= remain_nx;
         set_idle   <= idle_nx;
      end
   end

   // Next state: fan disable beats expiry, expiry beats the button,
   // the button beats an ordinary one-second decrement
   always_comb begin
      state_nx  = state;
      remain_nx = remain_sec;
      idle_nx   = 1'b0;
      pre_clr   = 1'b0;
      if (!fan_en) begin
         state_nx  = T_OFF;
         remain_nx = '0;
         pre_clr   = 1'b1;
      end else if (sec_tick && remain_sec == 16'd1) begin
         state_nx  = T_OFF;
         remain_nx = '0;
         idle_nx   = 1'b1;
         pre_clr   = 1'b1;
      end else if (btn_timer) begin
         state_nx = next_preset(state);
         pre_clr  = 1'b1;
         unique case (state_nx)
            T_1:     remain_nx = P1;
            T_2:     remain_nx = P2;
            T_3:     remain_nx = P3;
            default: remain_nx = '0;
         endcase
      end else if (sec_tick && remain_sec != '0) begin
         remain_nx = remain_sec - 16'd1;
      end
   end

`ifdef FAN_TIMER_WARN_EN
   localparam logic [15:0] WARN_V = 16'(WARN_SEC);

   // Warning registered from next-state values so it aligns with remain_sec
   always_ff @(posedge clk) begin
      if (reset_p) begin
         warn <= 1'b0;
      end else begin
         warn <= (state_nx != T_OFF) && (remain_nx != '0) && (remain_nx <= WARN_V);
      end
   end
`else
   assign warn = 1'b0;
`endif

endmodule

// File: tb/tb_fan_off_timer.sv
// Randomized scoreboard bench for fan_off_timer (CYC_PER_SEC=10, presets
// 3/6/9 s, WARN_SEC=2). Honors FAN_TIMER_WARN_EN the same way as the design.
module tb_fan_off_timer;

   localparam int CYC = 10;
   localparam int WS  = 2;

   typedef struct packed {
      logic [3:0]  st;
      logic [15:0] rem;
      logic        idle;
      logic        warn;
   } obs_t;

   logic        clk = 1'b0;
   logic        reset_p = 1'b1;
   logic        btn_timer = 1'b0;
   logic        fan_en = 1'b1;
   logic        run_e = 1'b1;
   logic        set_idle;
   logic [3:0]  timer_state;
   logic [15:0] remain_sec;
   logic        warn;

   obs_t q[$];
   obs_t got, want;
   int   total = 0;
   int   bad = 0;
   bit   active = 1'b0;
   int   idle_seen = 0;
   int   idle_exp = 0;

   // Reference model: preset index (0 = off), seconds left, cycles into second
   int   m_idx = 0;
   int   m_rem = 0;
   int   m_frac = 0;
   int   presets[4] = '{0, 3, 6, 9};

   fan_off_timer #(
      .CYC_PER_SEC (10),
      .PRESET_1    (3),
      .PRESET_2    (6),
      .PRESET_3    (9),
      .WARN_SEC    (2)
   ) dut (
      .clk         (clk),
      .reset_p     (reset_p),
      .btn_timer   (btn_timer),
      .fan_en      (fan_en),
      .run_e       (run_e),
      .set_idle    (set_idle),
      .timer_state (timer_state),
      .remain_sec  (remain_sec),
      .warn        (warn)
   );

   always #5 clk = ~clk;

   // Drive one cycle of inputs, predict the post-edge outputs, queue them
   task automatic step(input logic r, input logic b, input logic f, input logic e);
      obs_t x;
      bit   counting;
      bit   ticked;
      reset_p   = r;
      btn_timer = b;
      fan_en    = f;
      run_e     = e;
      x.idle    = 1'b0;
      if (r) begin
         m_idx = 0; m_rem = 0; m_frac = 0;
      end else if (!f) begin
         m_idx = 0; m_rem = 0; m_frac = 0;
      end else begin
         counting = (m_idx != 0) && e;
         ticked   = counting && (m_frac + 1 == CYC);
         if (ticked && m_rem == 1) begin
            m_idx = 0; m_rem = 0; m_frac = 0;
            x.idle = 1'b1;
         end else if (b) begin
            m_idx  = (m_idx + 1) % 4;
            m_rem  = presets[m_idx];
            m_frac = 0;
         end else if (counting) begin
            m_frac = (m_frac + 1) % CYC;
            if (ticked && m_rem > 0) m_rem = m_rem - 1;
         end
      end
      x.st  = 4'(1 << m_idx);
      x.rem = 16'(m_rem);
`ifdef FAN_TIMER_WARN_EN
      x.warn = (m_idx != 0) && (m_rem > 0) && (m_rem <= WS);
`else
      x.warn = 1'b0;
`endif
      if (x.idle) idle_exp++;
      q.push_back(x);
      @(posedge clk);
      #2;
   endtask

   task automatic run(input int n, input logic e);
      for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b1, e);
   endtask

   // Monitor: compare every post-edge observation against the queue head
   always @(posedge clk) begin
      #1;
      if (active) begin
         total++;
         got = {timer_state, remain_sec, set_idle, warn};
         if (q.size() == 0) begin
            bad++;
            $display("FAIL underrun t=%0t: no expected entry queued", $time);
         end else begin
            want = q.pop_front();
            if (got !== want) begin
               bad++;
               $display("FAIL outputs t=%0t: got st=%b rem=%0d idle=%b warn=%b, want st=%b rem=%0d idle=%b warn=%b",
                        $time, got.st, got.rem, got.idle, got.warn,
                        want.st, want.rem, want.idle, want.warn);
            end
         end
         if (set_idle === 1'b1) idle_seen++;
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: bench did not finish in time");
      $fatal(1);
   end

   initial begin
      active = 1'b1;
      step(1'b1, 1'b0, 1'b1, 1'b1);
      step(1'b1, 1'b0, 1'b1, 1'b1);

      // Single preset counts down and expires
      step(1'b0, 1'b1, 1'b1, 1'b1);
      run(40, 1'b1);

      // Four presses cycle through all states back to off
      for (int k = 0; k < 4; k++) begin
         step(1'b0, 1'b1, 1'b1, 1'b1);
         run(4, 1'b1);
      end

      // Pause with run_e low, then resume to expiry
      step(1'b0, 1'b1, 1'b1, 1'b1);
      run(15, 1'b1);
      run(50, 1'b0);
      run(20, 1'b1);

      // Button pressed on the expiry cycle
      step(1'b0, 1'b1, 1'b1, 1'b1);
      run(29, 1'b1);
      step(1'b0, 1'b1, 1'b1, 1'b1);
      run(5, 1'b1);

      // Fan disabled mid-count in T_2
      step(1'b0, 1'b1, 1'b1, 1'b1);
      step(1'b0, 1'b1, 1'b1, 1'b1);
      run(12, 1'b1);
      step(1'b0, 1'b1, 1'b0, 1'b1);
      run(5, 1'b1);

      // Reset at remain_sec=1 discards the countdown
      step(1'b0, 1'b1, 1'b1, 1'b1);
      run(25, 1'b1);
      step(1'b1, 1'b0, 1'b1, 1'b1);
      run(15, 1'b1);

      // Randomized traffic
      for (int i = 0; i < 2000; i++) begin
         step(1'($urandom_range(199) == 0),
              1'($urandom_range(59) == 0),
              1'($urandom_range(99) != 0),
              1'($urandom_range(9) != 0));
      end
      run(3, 1'b1);
      active = 1'b0;

      total++;
      if (idle_seen != idle_exp) begin
         bad++;
         $display("FAIL idle_count: got %0d pulses, want %0d", idle_seen, idle_exp);
      end
      total++;
      if (q.size() != 0) begin
         bad++;
         $display("FAIL queue_drain: %0d entries left, want 0", q.size());
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
